// File: rtl/sym_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sym_counter_pkg
//  Description : Shared definitions for the symbol-counting game: seven-segment
//                constants and digit encoder, FSM state codes, verdict codes
//                and the 0..99 clamp used on every displayed count.
//  Revision    : 1.0 - initial release
// ============================================================================
package sym_counter_pkg;

    // Active-low segment bytes
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // result_period FSM state codes
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPARE = 2'd1;
    localparam logic [1:0] SHOW    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    // Verdict encoding
    localparam logic [1:0] VERDICT_NONE  = 2'd0;
    localparam logic [1:0] VERDICT_MISS  = 2'd1;
    localparam logic [1:0] VERDICT_CLOSE = 2'd2;
    localparam logic [1:0] VERDICT_EXACT = 2'd3;

    localparam logic [6:0] COUNT_MAX = 7'd99;

    // Decimal digit to active-low segment byte; anything outside 0..9 is blank.
    function automatic logic [7:0] intToSeg(input logic [3:0] digit);
        case (digit)
            4'd0:    intToSeg = 8'hC0;
            4'd1:    intToSeg = 8'hF9;
            4'd2:    intToSeg = 8'hA4;
            4'd3:    intToSeg = 8'hB0;
            4'd4:    intToSeg = 8'h99;
            4'd5:    intToSeg = 8'h92;
            4'd6:    intToSeg = 8'h82;
            4'd7:    intToSeg = 8'hD8;
            4'd8:    intToSeg = 8'h80;
            4'd9:    intToSeg = 8'h90;
            default: intToSeg = SEG_BLANK;
        endcase
    endfunction

    // Counts only ever display as two digits, so anything above 99 pins to 99.
    function automatic logic [6:0] clamp99(input logic [6:0] value);
        clamp99 = (value > COUNT_MAX) ? COUNT_MAX : value;
    endfunction

endpackage : sym_counter_pkg
`default_nettype wire

// File: rtl/two_digit_seg.sv
`default_nettype none
// ============================================================================
//  Module      : two_digit_seg
//  Description : Converts a 7-bit value 0..99 into tens/ones active-low
//                segment bytes, with an override that blanks both digits.
//  Ports       : value   in  7  binary value, 0..99
//                blank   in  1  force both digits to SEG_BLANK
//                segTens out 8  tens digit segment byte
//                segOnes out 8  ones digit segment byte
//  Revision    : 1.0 - initial release
// ============================================================================
module two_digit_seg (
    input  logic [6:0] value,
    input  logic       blank,
    output logic [7:0] segTens,
    output logic [7:0] segOnes
);
    import sym_counter_pkg::*;

    logic [3:0] w_tens;
    logic [3:0] w_ones;

    always_comb begin
        w_tens = 4'(value / 7'd10);
        w_ones = 4'(value % 7'd10);
        if (blank) begin
            segTens = SEG_BLANK;
            segOnes = SEG_BLANK;
        end else begin
            segTens = intToSeg(w_tens);
            segOnes = intToSeg(w_ones);
        end
    end

endmodule : two_digit_seg
`default_nettype wire

// File: rtl/result_period.sv
`default_nettype none
// ============================================================================
//  Module      : result_period
//  Description : Scoring stage of the symbol-counting game. On postSig it
//                latches the clamped player and true counts, awards points to
//                a saturating score, displays true count and score for
//                DISPLAY_SECS seconds, then pulses nextRoundSig.
//  Ports       : Clk100M      in  1  system clock
//                Reset        in  1  synchronous active-high reset
//                tick1Hz      in  1  one-cycle strobe per second
//                postSig      in  1  answer period over
//                userCount    in  7  player's count
//                symbolCount  in  7  true symbol count
//                resultSeg0/1 out 8  true count tens/ones (blank outside SHOW)
//                resultSeg2/3 out 8  score tens/ones
//                verdict      out 2  0 none, 1 miss, 2 close, 3 exact
//                busy         out 1  FSM not in IDLE
//                nextRoundSig out 1  one-cycle pulse at end of display time
//  Revision    : 1.0 - initial release
// ============================================================================
module result_period #(
    parameter int DISPLAY_SECS = 3,
    parameter int EXACT_PTS    = 2,
    parameter int CLOSE_PTS    = 1,
    parameter int CLOSE_MARGIN = 1,
    parameter int MAX_SCORE    = 99
) (
    input  logic       Clk100M,
    input  logic       Reset,
    input  logic       tick1Hz,
    input  logic       postSig,
    input  logic [6:0] userCount,
    input  logic [6:0] symbolCount,
    output logic [7:0] resultSeg0,
    output logic [7:0] resultSeg1,
    output logic [7:0] resultSeg2,
    output logic [7:0] resultSeg3,
    output logic [1:0] verdict,
    output logic       busy,
    output logic       nextRoundSig
);
    import sym_counter_pkg::*;

    localparam logic [3:0] c_LAST_SEC  = 4'(DISPLAY_SECS - 1);
    localparam logic [7:0] c_EXACT_PTS = 8'(EXACT_PTS);
    localparam logic [7:0] c_CLOSE_PTS = 8'(CLOSE_PTS);
    localparam logic [6:0] c_MARGIN    = 7'(CLOSE_MARGIN);
    localparam logic [7:0] c_MAX_SCORE = 8'(MAX_SCORE);

    logic [1:0] r_state;
    logic [6:0] r_user;
    logic [6:0] r_symbol;
    logic [6:0] r_score;
    logic [3:0] r_secCnt;
    logic [1:0] r_verdict;

    logic [6:0] w_diff;
    logic [1:0] w_verdict;
    logic [7:0] w_pts;
    logic [7:0] w_sum;
    logic [6:0] w_newScore;

    // Scoring: the sum is formed one bit wider so it can never wrap before
    // the saturation compare.
    always_comb begin
        w_diff = (r_user >= r_symbol) ? (r_user - r_symbol) : (r_symbol - r_user);
        if (w_diff == 7'd0) begin
            w_verdict = VERDICT_EXACT;
            w_pts     = c_EXACT_PTS;
        end else if (w_diff <= c_MARGIN) begin
            w_verdict = VERDICT_CLOSE;
            w_pts     = c_CLOSE_PTS;
        end else begin
            w_verdict = VERDICT_MISS;
            w_pts     = 8'd0;
        end
        w_sum      = {1'b0, r_score} + w_pts;
        w_newScore = (w_sum > c_MAX_SCORE) ? c_MAX_SCORE[6:0] : w_sum[6:0];
    end

    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_user    <= 7'd0;
            r_symbol  <= 7'd0;
            r_score   <= 7'd0;
            r_secCnt  <= 4'd0;
            r_verdict <= VERDICT_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (postSig) begin
                        r_user   <= clamp99(userCount);
                        r_symbol <= clamp99(symbolCount);
                        r_state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    r_verdict <= w_verdict;
                    r_score   <= w_newScore;
                    r_secCnt  <= 4'd0;
                    r_state   <= SHOW;
                end
                SHOW: begin
                    if (tick1Hz) begin
                        r_secCnt <= r_secCnt + 4'd1;
                        // Verdict clears on entry so it already reads 0 during DONE.
                        if (r_secCnt == c_LAST_SEC) begin
                            r_verdict <= VERDICT_NONE;
                            r_state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // True count is only meaningful once COMPARE has run; blank otherwise.
    two_digit_seg u_count_seg (
        .value   (r_symbol),
        .blank   (r_state != SHOW),
        .segTens (resultSeg0),
        .segOnes (resultSeg1)
    );

    two_digit_seg u_score_seg (
        .value   (r_score),
        .blank   (1'b0),
        .segTens (resultSeg2),
        .segOnes (resultSeg3)
    );

    assign verdict      = r_verdict;
    assign busy         = (r_state != IDLE);
    assign nextRoundSig = (r_state == DONE);

endmodule : result_period
`default_nettype wire

// File: tb/tb_result_period.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_period
//  Description : Scoreboard bench for result_period. The driver pushes the
//                model's expected verdict/score/true count for every accepted
//                postSig; a monitor pops and compares when verdict becomes valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_period;

    localparam int DISPLAY_SECS = 3;
    localparam int EXACT_PTS    = 2;
    localparam int CLOSE_PTS    = 1;
    localparam int CLOSE_MARGIN = 1;
    localparam int MAX_SCORE    = 99;

    logic       Clk100M = 1'b0;
    logic       Reset = 1'b1;
    logic       tick1Hz = 1'b0;
    logic       postSig = 1'b0;
    logic [6:0] userCount = 7'd0;
    logic [6:0] symbolCount = 7'd0;
    logic [7:0] resultSeg0, resultSeg1, resultSeg2, resultSeg3;
    logic [1:0] verdict;
    logic       busy, nextRoundSig;

    result_period #(
        .DISPLAY_SECS (DISPLAY_SECS),
        .EXACT_PTS    (EXACT_PTS),
        .CLOSE_PTS    (CLOSE_PTS),
        .CLOSE_MARGIN (CLOSE_MARGIN),
        .MAX_SCORE    (MAX_SCORE)
    ) dut (
        .Clk100M      (Clk100M),
        .Reset        (Reset),
        .tick1Hz      (tick1Hz),
        .postSig      (postSig),
        .userCount    (userCount),
        .symbolCount  (symbolCount),
        .resultSeg0   (resultSeg0),
        .resultSeg1   (resultSeg1),
        .resultSeg2   (resultSeg2),
        .resultSeg3   (resultSeg3),
        .verdict      (verdict),
        .busy         (busy),
        .nextRoundSig (nextRoundSig)
    );

    always #5 Clk100M = ~Clk100M;

    typedef struct {
        int verdict;
        int score;
        int truth;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         model_score = 0;
    logic [7:0] segTab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hD8, 8'h80, 8'h90};

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference scoring straight from the game rules.
    task automatic model_push(input int u, input int s);
        exp_t e;
        int uc, sc, d;
        uc = (u > 99) ? 99 : u;
        sc = (s > 99) ? 99 : s;
        d  = (uc > sc) ? uc - sc : sc - uc;
        if (d == 0) begin
            e.verdict   = 3;
            model_score = model_score + EXACT_PTS;
        end else if (d <= CLOSE_MARGIN) begin
            e.verdict   = 2;
            model_score = model_score + CLOSE_PTS;
        end else begin
            e.verdict   = 1;
        end
        if (model_score > MAX_SCORE) model_score = MAX_SCORE;
        e.score = model_score;
        e.truth = sc;
        exp_q.push_back(e);
    endtask

    // Monitor: verdict leaving 0 marks a freshly valid result.
    initial begin : monitor
        logic [1:0] prevV;
        exp_t e;
        prevV = 2'd0;
        forever begin
            @(negedge Clk100M);
            if (prevV == 2'd0 && verdict != 2'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("verdict", verdict, e.verdict);
                    chk("seg0_truth_tens", resultSeg0, segTab[e.truth / 10]);
                    chk("seg1_truth_ones", resultSeg1, segTab[e.truth % 10]);
                    chk("seg2_score_tens", resultSeg2, segTab[e.score / 10]);
                    chk("seg3_score_ones", resultSeg3, segTab[e.score % 10]);
                end
            end
            prevV = verdict;
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_seg0"}, resultSeg0, 8'hFF);
        chk({tag, "_seg1"}, resultSeg1, 8'hFF);
        chk({tag, "_seg2"}, resultSeg2, 8'hC0);
        chk({tag, "_seg3"}, resultSeg3, 8'hC0);
        chk({tag, "_verdict"}, verdict, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_next"}, nextRoundSig, 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk100M);
        Reset = 1'b0;
        model_score = 0;
        check_idle("reset");
    endtask

    // Issues postSig; optionally holds tick1Hz high through the accept and
    // COMPARE cycles, where it must not count. Ends at the first SHOW cycle.
    task automatic start_round(input int u, input int s, input bit coinc);
        postSig     = 1'b1;
        userCount   = 7'(u);
        symbolCount = 7'(s);
        tick1Hz     = coinc;
        model_push(u, s);
        @(negedge Clk100M);
        postSig = 1'b0;
        chk("busy_after_post", busy, 1);
        @(negedge Clk100M);
        tick1Hz = 1'b0;
    endtask

    // Delivers DISPLAY_SECS ticks with random gaps; optionally re-pulses
    // postSig alongside the first tick, which must be ignored.
    task automatic finish_round(input bit extraPost);
        int gap;
        for (int k = 0; k < DISPLAY_SECS; k++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) @(negedge Clk100M);
            if (k == DISPLAY_SECS - 1) chk("no_early_next", nextRoundSig, 0);
            tick1Hz = 1'b1;
            if (extraPost && k == 0) begin
                postSig     = 1'b1;
                userCount   = 7'($urandom_range(0, 127));
                symbolCount = 7'($urandom_range(0, 127));
            end
            @(negedge Clk100M);
            tick1Hz = 1'b0;
            postSig = 1'b0;
        end
        chk("next_pulse", nextRoundSig, 1);
        chk("busy_in_done", busy, 1);
        chk("done_verdict", verdict, 0);
        chk("done_seg0", resultSeg0, 8'hFF);
        chk("done_seg1", resultSeg1, 8'hFF);
        @(negedge Clk100M);
        chk("next_fall", nextRoundSig, 0);
        chk("busy_fall", busy, 0);
    endtask

    task automatic round(input int u, input int s, input bit coinc, input bit extraPost);
        start_round(u, s, coinc);
        finish_round(extraPost);
    endtask

    initial begin : driver
        int u, s;
        @(negedge Clk100M);
        do_reset();

        // Directed rounds
        round(12, 12, 1'b0, 1'b0);   // exact, score 2
        round(7, 8, 1'b1, 1'b1);     // close, score 3; coincident tick and stray post ignored
        round(20, 5, 1'b0, 1'b0);    // miss, score 3
        round(120, 99, 1'b0, 1'b0);  // clamped exact, score 5

        // Reset in the middle of SHOW at score 5
        start_round(50, 10, 1'b0);
        tick1Hz = 1'b1;
        @(negedge Clk100M);
        tick1Hz = 1'b0;
        Reset   = 1'b1;
        @(negedge Clk100M);
        Reset = 1'b0;
        model_score = 0;
        check_idle("midshow_reset");
        for (int i = 0; i < 4; i++) begin
            tick1Hz = 1'b1;
            @(negedge Clk100M);
            chk("no_next_after_reset", nextRoundSig, 0);
        end
        tick1Hz = 1'b0;

        // Randomized rounds
        for (int i = 0; i < 30; i++) begin
            u = $urandom_range(0, 127);
            case ($urandom_range(0, 2))
                0:       s = u;
                1:       s = (u + $urandom_range(0, 4) > 2) ? u + $urandom_range(0, 4) - 2 : 0;
                default: s = $urandom_range(0, 127);
            endcase
            if (s > 127) s = 127;
            round(u, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Saturation: 49 exact rounds reach 98, one more pins at 99
        do_reset();
        for (int i = 0; i < 50; i++) begin
            u = $urandom_range(0, 127);
            round(u, u, 1'b0, 1'b0);
        end
        chk("sat_seg2", resultSeg2, 8'h90);
        chk("sat_seg3", resultSeg3, 8'h90);

        repeat (3) @(negedge Clk100M);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_result_period
`default_nettype wire
